pipeline_sequencer: RTL
=======================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: port list begins clk, rst_n.
REQ-002 Parameter OP_ADDI, default 2'b00, addi opcode.
REQ-003 Parameter OP_SLL, default 2'b01, sll opcode.
REQ-004 Parameter OP_JMP, default 2'b11, jmp opcode; 2'b10 is illegal.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 run  in  1  level; 1 = fetch enabled.
REQ-008 stall_req  in  1  external stall (memory/IO not ready).
REQ-009 id_opcode  in  2  opcode of instruction in ID.
REQ-010 id_rd, id_rs  in  3 each  destination and source register of instruction in ID.
REQ-011 pc_en, pc_load  out  1 each  PC advance; PC load with jump target.
REQ-012 ifid_en, ifid_flush, idex_bubble  out  1 each  pipeline register controls.
REQ-013 stage_valid  out  4  valid bits {WB,EX,ID,IF}.
REQ-014 fwd_sel  out  2  ID source select: 0 regfile, 1 EX result, 2 WB result.
REQ-015 retired  out  8  retired-instruction count.
REQ-016 state  out  2  current FSM state; illegal  out  1  sticky illegal-opcode flag.

Function
REQ-017 FSM states SHALL be IDLE=0, RUN=1, FLUSH=2, HALT=3.
REQ-018 IDLE: pc_en=ifid_en=0, stage_valid shifts left inserting 0 (drain); go RUN when run=1.
REQ-019 RUN: when stall_req=0, pc_en=ifid_en=1, stage_valid <= {stage_valid[2:0],1}.
REQ-020 RUN with run=0: go IDLE next cycle; in-flight instructions drain.
REQ-021 stall_req=1 (any state but HALT): pc_en=ifid_en=0, IF/ID valid held, idex_bubble=1, EX valid <= 0, WB valid <= old EX valid.
REQ-022 Jump: stage_valid[1]=1, id_opcode=OP_JMP, stall_req=0 -> pc_load=1 and ifid_flush=1 combinationally same cycle; next cycle ID valid=0, state FLUSH.
REQ-023 FLUSH: lasts exactly one cycle with normal advance; then RUN (or IDLE if run=0); one-cycle jump penalty.
REQ-024 Jump concurrent with stall_req=1: jump SHALL be deferred until stall clears; pc_load=0 while stalled.
REQ-025 Illegal: stage_valid[1]=1, id_opcode=2'b10 -> illegal<=1, state HALT next cycle.
REQ-026 HALT: all enables 0, stage_valid<=0, retired frozen; exit only by reset.
REQ-027 EX/WB destination tracking: on ID->EX advance register id_rd and writes-reg flag (1 for ADDI/SLL, 0 for JMP/bubble); copy EX->WB.
REQ-028 fwd_sel=1 when ID valid, EX valid, EX writes, ex_rd==id_rs; else 2 on same match in WB; else 0; EX priority over WB.
REQ-029 Register 0 SHALL never forward (id_rs=0 -> fwd_sel=0).
REQ-030 retired SHALL increment on each cycle with WB valid=1 and state!=HALT, wrapping 8'hFF->8'h00.

Reset
REQ-031 rst_n=0 asynchronously: state=IDLE, stage_valid=0, retired=0, illegal=0, tracked rd/flags=0; all combinational outputs 0 while in reset.
REQ-032 Reset mid-jump or mid-stall SHALL discard the pending action; no pc_load after release.

Structure
REQ-033 Opcode values, FSM state encodings and fwd_sel encodings SHALL live in a shared package pipe_pkg.
REQ-034 Forwarding compare SHALL be one sub-module fwd_unit (pure combinational); FSM, valid vector and counter in pipeline_sequencer.

Verification
REQ-035 Reset, run=1, four ADDIs, no stall -> stage_valid 0001,0011,0111,1111 on cycles 1-4; retired=1 at cycle 5.
REQ-036 ADDI r3 then SLL rs=r3 back-to-back -> fwd_sel=1 when SLL in ID; one cycle later with unrelated instruction in ID matching r3 -> fwd_sel=2.
REQ-037 JMP in ID -> pc_load=1, ifid_flush=1 same cycle; next cycle state=FLUSH, stage_valid[1]=0; cycle after state=RUN.
REQ-038 stall_req high 3 cycles during RUN -> pc_en=0 for 3 cycles, EX valid=0 bubbles, retired unchanged after drain then resumes.
REQ-039 Opcode 2'b10 in ID -> illegal=1, state=HALT, stage_valid=0; rst_n pulse returns to IDLE with illegal=0.
REQ-040 Run 260 instructions -> retired wraps to 8'd4.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline sequencer: opcodes, FSM states and
// forwarding-select values.
package pipe_pkg;

  localparam logic [1:0] OPC_ADDI = 2'b00;
  localparam logic [1:0] OPC_SLL  = 2'b01;
  localparam logic [1:0] OPC_ILL  = 2'b10;
  localparam logic [1:0] OPC_JMP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_EX = 2'd1,
    FWD_WB = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for the ID-stage source register; EX beats WB,
// and register 0 is hardwired so it never forwards.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic       id_valid,
  input  logic [2:0] id_rs,
  input  logic       ex_valid,
  input  logic       ex_wr,
  input  logic [2:0] ex_rd,
  input  logic       wb_valid,
  input  logic       wb_wr,
  input  logic [2:0] wb_rd,
  output fwd_sel_t   fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (id_valid && (id_rs != 3'd0)) begin
      if (ex_valid && ex_wr && (ex_rd == id_rs))
        fwd_sel = FWD_EX;
      else if (wb_valid && wb_wr && (wb_rd == id_rs))
        fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Four-stage (IF/ID/EX/WB) pipeline controller: run/stall/jump/halt FSM,
// stage valid vector, destination tracking and retired-instruction counter.
//
// stall_req is a level: while high the front end (IF/ID) holds, EX receives
// a bubble and WB still drains; nothing is acknowledged back.
module pipeline_sequencer
  import pipe_pkg::*;
#(
  parameter logic [1:0] OP_ADDI = OPC_ADDI,
  parameter logic [1:0] OP_SLL  = OPC_SLL,
  parameter logic [1:0] OP_JMP  = OPC_JMP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       stall_req,
  input  logic [1:0] id_opcode,
  input  logic [2:0] id_rd,
  input  logic [2:0] id_rs,
  output logic       pc_en,
  output logic       pc_load,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic [3:0] stage_valid,
  output logic [1:0] fwd_sel,
  output logic [7:0] retired,
  output logic [1:0] state,
  output logic       illegal
);

  state_t     state_q;
  logic [3:0] sv_q;
  logic [2:0] ex_rd_q, wb_rd_q;
  logic       ex_wr_q, wb_wr_q;

  logic       is_ill, is_jmp;
  logic       pc_en_c, pc_load_c, ifid_en_c, ifid_flush_c, bubble_c;
  logic       fetch_bit;
  fwd_sel_t   fwd_c;

  always_comb begin
    is_ill       = 1'b0;
    is_jmp       = 1'b0;
    pc_en_c      = 1'b0;
    pc_load_c    = 1'b0;
    ifid_en_c    = 1'b0;
    ifid_flush_c = 1'b0;
    bubble_c     = 1'b0;
    fetch_bit    = (state_q != ST_IDLE);
    if (state_q != ST_HALT) begin
      is_ill = sv_q[1] && (id_opcode == OPC_ILL);
      // A jump waiting behind a stall stays in ID and is taken once it clears.
      is_jmp = sv_q[1] && (id_opcode == OP_JMP) && !stall_req;
      if (stall_req) begin
        bubble_c = 1'b1;
      end else begin
        pc_en_c      = fetch_bit;
        ifid_en_c    = fetch_bit;
        pc_load_c    = is_jmp;
        ifid_flush_c = is_jmp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sv_q    <= 4'b0000;
      ex_rd_q <= 3'd0;
      ex_wr_q <= 1'b0;
      wb_rd_q <= 3'd0;
      wb_wr_q <= 1'b0;
      retired <= 8'd0;
      illegal <= 1'b0;
    end else if (state_q == ST_HALT) begin
      sv_q    <= 4'b0000;
      ex_wr_q <= 1'b0;
      wb_wr_q <= 1'b0;
    end else begin
      retired <= retired + {7'd0, sv_q[3]};
      wb_rd_q <= ex_rd_q;
      wb_wr_q <= ex_wr_q;
      if (is_ill) begin
        illegal <= 1'b1;
        state_q <= ST_HALT;
        sv_q    <= 4'b0000;
        ex_wr_q <= 1'b0;
      end else begin
        state_q <= is_jmp ? ST_FLUSH : (run ? ST_RUN : ST_IDLE);
        if (stall_req) begin
          sv_q    <= {sv_q[2], 1'b0, sv_q[1:0]};
          ex_wr_q <= 1'b0;
        end else begin
          sv_q    <= {sv_q[2], sv_q[1], sv_q[0] & ~is_jmp, fetch_bit};
          ex_rd_q <= id_rd;
          ex_wr_q <= sv_q[1] && ((id_opcode == OP_ADDI) || (id_opcode == OP_SLL));
        end
      end
    end
  end

  fwd_unit u_fwd (
    .id_valid (sv_q[1]),
    .id_rs    (id_rs),
    .ex_valid (sv_q[2]),
    .ex_wr    (ex_wr_q),
    .ex_rd    (ex_rd_q),
    .wb_valid (sv_q[3]),
    .wb_wr    (wb_wr_q),
    .wb_rd    (wb_rd_q),
    .fwd_sel  (fwd_c)
  );

  assign pc_en       = rst_n & pc_en_c;
  assign pc_load     = rst_n & pc_load_c;
  assign ifid_en     = rst_n & ifid_en_c;
  assign ifid_flush  = rst_n & ifid_flush_c;
  assign idex_bubble = rst_n & bubble_c;
  assign fwd_sel     = rst_n ? 2'(fwd_c) : 2'b00;
  assign stage_valid = sv_q;
  assign state       = 2'(state_q);

endmodule
